// File: rtl/game_flow_controller.sv
// Game sequencer: paces one physics update per rendered frame, runs the
// idle/serve/play/level-clear/game-over flow and owns the lives counter.
module game_flow_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int CLEAR_FRAMES = 120
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_rendered_i,
  input  logic        sw_pause_i,
  input  logic        btn_release_i,
  input  logic        update_done_i,
  input  logic        ball_lost_i,
  input  logic [71:0] block_state_i,
  output logic        start_update_o,
  output logic        physics_reset_o,
  output logic        ball_reset_o,
  output logic [2:0]  game_state_o,
  output logic [2:0]  lives_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SERVE       = 3'd1,
    S_PLAY        = 3'd2,
    S_LEVEL_CLEAR = 3'd3,
    S_GAME_OVER   = 3'd4
  } state_e;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_FRAMES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       btn_q;
  logic       start_q, start_d;
  logic       phys_q, phys_d;
  logic       ball_q, ball_d;

  logic frame, press, done, left_play;

  assign frame = frame_rendered_i & ~sw_pause_i;
  assign press = btn_release_i & ~btn_q;
  assign done  = update_done_i & busy_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      lives_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      btn_q   <= 1'b1;  // a button held through reset must not count as a press
      start_q <= 1'b0;
      phys_q  <= 1'b0;
      ball_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      btn_q   <= btn_release_i;
      start_q <= start_d;
      phys_q  <= phys_d;
      ball_q  <= ball_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ovr_d     = ovr_q;
    start_d   = 1'b0;
    phys_d    = 1'b0;
    ball_d    = 1'b0;
    left_play = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (press) begin
          state_d = S_SERVE;
          lives_d = LIVES_LOAD;
          cnt_d   = SERVE_LOAD;
          phys_d  = 1'b1;
        end
      end
      S_SERVE: begin
        if (frame) begin
          if (cnt_q == 8'd0) state_d = S_PLAY;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      S_LEVEL_CLEAR: begin
        if (frame) begin
          if (cnt_q == 8'd0) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_LOAD;
            phys_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      S_PLAY: begin
        // Completion is evaluated before a coincident frame is considered.
        if (done) begin
          busy_d = 1'b0;
          if (block_state_i == '0) begin
            state_d   = S_LEVEL_CLEAR;
            cnt_d     = CLEAR_LOAD;
            left_play = 1'b1;
          end else if (ball_lost_i) begin
            left_play = 1'b1;
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              ball_d  = 1'b1;
              state_d = S_SERVE;
              cnt_d   = SERVE_LOAD;
            end else begin
              lives_d = 3'd0;
              state_d = S_GAME_OVER;
            end
          end
        end
        if (frame && !left_play) begin
          if (!busy_d) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign start_update_o  = start_q;
  assign physics_reset_o = phys_q;
  assign ball_reset_o    = ball_q;
  assign game_state_o    = state_q;
  assign lives_o         = lives_q;
  assign overrun_o       = ovr_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed scenarios plus random stimulus
// checked against a frame-level reference model.
module tb_game_flow_controller;

  localparam int LI = 3;
  localparam int SF = 4;
  localparam int CF = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame = 1'b0, pause = 1'b0, btn = 1'b1;
  logic        done = 1'b0, lost = 1'b0;
  logic [71:0] blocks = 72'h1;
  logic        start_o, phys_o, ball_o, ovr_o;
  logic [2:0]  state_o, lives_o;

  int checks = 0;
  int errs   = 0;

  // reference model: frames_left counts remaining frames of a timed state
  int m_state, m_lives, m_left;
  bit m_busy, m_ovr, m_prev, m_start, m_phys, m_ball;

  game_flow_controller #(.LIVES_INIT(LI), .SERVE_FRAMES(SF), .CLEAR_FRAMES(CF)) dut (
    .clk_i(clk), .reset_i(reset), .frame_rendered_i(frame), .sw_pause_i(pause),
    .btn_release_i(btn), .update_done_i(done), .ball_lost_i(lost),
    .block_state_i(blocks), .start_update_o(start_o), .physics_reset_o(phys_o),
    .ball_reset_o(ball_o), .game_state_o(state_o), .lives_o(lives_o), .overrun_o(ovr_o)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit fr, pr, exited;
    if (reset) begin
      m_state = 0; m_lives = 0; m_left = 0; m_busy = 0; m_ovr = 0;
      m_prev = 1; m_start = 0; m_phys = 0; m_ball = 0;
      return;
    end
    fr = frame && !pause;
    pr = btn && !m_prev;
    m_prev = btn;
    m_start = 0; m_phys = 0; m_ball = 0;
    exited = 0;
    case (m_state)
      0, 4: if (pr) begin m_state = 1; m_lives = LI; m_left = SF; m_phys = 1; end
      1: if (fr) begin m_left--; if (m_left == 0) m_state = 2; end
      3: if (fr) begin
           m_left--;
           if (m_left == 0) begin m_state = 1; m_left = SF; m_phys = 1; end
         end
      2: begin
           if (done && m_busy) begin
             m_busy = 0;
             if (blocks == 72'd0) begin m_state = 3; m_left = CF; exited = 1; end
             else if (lost) begin
               exited = 1;
               if (m_lives > 1) begin m_lives--; m_ball = 1; m_state = 1; m_left = SF; end
               else begin m_lives = 0; m_state = 4; end
             end
           end
           if (fr && !exited) begin
             if (!m_busy) begin m_start = 1; m_busy = 1; end
             else m_ovr = 1;
           end
         end
      default: ;
    endcase
  endtask

  // one clock: DUT and model consume current inputs, pulse inputs then clear
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    frame = 0; done = 0; lost = 0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin frame = 1; tick(); tick(); end
  endtask

  task automatic enter_play_busy();
    run_frames(SF);
    frame = 1; tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1; btn = 1; tick(); tick(); reset = 0;
    checks++;
    if ({state_o, lives_o, start_o, phys_o, ball_o, ovr_o} !== 10'd0) begin
      errs++; $display("FAIL reset_values got st=%0d lv=%0d su=%b pr=%b br=%b ov=%b want all 0",
                       state_o, lives_o, start_o, phys_o, ball_o, ovr_o);
    end
    for (int i = 0; i < 5; i++) begin
      frame = 1; tick();
      checks++;
      if (state_o !== 3'd0 || phys_o !== 1'b0 || start_o !== 1'b0) begin
        errs++; $display("FAIL held_btn_idle got st=%0d pr=%b su=%b want 0 0 0", state_o, phys_o, start_o);
      end
    end
    btn = 0; tick(); btn = 1; tick();
    checks++;
    if (phys_o !== 1'b1 || state_o !== 3'd1 || lives_o !== 3'(LI) || ball_o !== 1'b0) begin
      errs++; $display("FAIL press_start got pr=%b st=%0d lv=%0d br=%b want 1 1 %0d 0", phys_o, state_o, lives_o, ball_o, LI);
    end
    tick();
    checks++;
    if (phys_o !== 1'b0) begin errs++; $display("FAIL phys_pulse_width got %b want 0", phys_o); end
    btn = 0;
  endtask

  task automatic test_serve();
    run_frames(SF - 1);
    checks++;
    if (state_o !== 3'd1) begin errs++; $display("FAIL serve_hold got %0d want 1", state_o); end
    frame = 1; tick();
    checks++;
    if (state_o !== 3'd2 || start_o !== 1'b0) begin
      errs++; $display("FAIL serve_exit got st=%0d su=%b want 2 0", state_o, start_o);
    end
    tick(); frame = 1; tick();
    checks++;
    if (start_o !== 1'b1) begin errs++; $display("FAIL start_latency got %b want 1", start_o); end
    tick();
    checks++;
    if (start_o !== 1'b0) begin errs++; $display("FAIL start_width got %b want 0", start_o); end
  endtask

  task automatic test_lives();
    for (int l = LI; l >= 1; l--) begin
      done = 1; lost = 1; blocks = 72'h80_0000_0000_0000_0001; tick();
      checks++;
      if (l > 1) begin
        if (lives_o !== 3'(l - 1) || ball_o !== 1'b1 || state_o !== 3'd1 || phys_o !== 1'b0) begin
          errs++; $display("FAIL ball_lost got lv=%0d br=%b st=%0d pr=%b want %0d 1 1 0", lives_o, ball_o, state_o, phys_o, l - 1);
        end
        tick();
        checks++;
        if (ball_o !== 1'b0) begin errs++; $display("FAIL ball_width got %b want 0", ball_o); end
        enter_play_busy();
      end else begin
        if (lives_o !== 3'd0 || state_o !== 3'd4 || ball_o !== 1'b0) begin
          errs++; $display("FAIL game_over got lv=%0d st=%0d br=%b want 0 4 0", lives_o, state_o, ball_o);
        end
      end
    end
    run_frames(3);
    checks++;
    if (state_o !== 3'd4) begin errs++; $display("FAIL game_over_hold got %0d want 4", state_o); end
    btn = 1; tick(); btn = 0;
    checks++;
    if (state_o !== 3'd1 || lives_o !== 3'(LI) || phys_o !== 1'b1) begin
      errs++; $display("FAIL restart got st=%0d lv=%0d pr=%b want 1 %0d 1", state_o, lives_o, phys_o, LI);
    end
  endtask

  task automatic test_level_clear();
    enter_play_busy();
    done = 1; lost = 1; blocks = 72'd0; tick();
    checks++;
    if (state_o !== 3'd3 || lives_o !== 3'(LI) || ball_o !== 1'b0) begin
      errs++; $display("FAIL clear_entry got st=%0d lv=%0d br=%b want 3 %0d 0", state_o, lives_o, ball_o, LI);
    end
    blocks = 72'h1;
    run_frames(CF - 1);
    checks++;
    if (state_o !== 3'd3 || phys_o !== 1'b0) begin
      errs++; $display("FAIL clear_hold got st=%0d pr=%b want 3 0", state_o, phys_o);
    end
    frame = 1; tick();
    checks++;
    if (state_o !== 3'd1 || phys_o !== 1'b1 || lives_o !== 3'(LI)) begin
      errs++; $display("FAIL clear_exit got st=%0d pr=%b lv=%0d want 1 1 %0d", state_o, phys_o, lives_o, LI);
    end
  endtask

  task automatic test_overrun();
    enter_play_busy();
    frame = 1; done = 1; tick();
    checks++;
    if (start_o !== 1'b1 || ovr_o !== 1'b0) begin
      errs++; $display("FAIL coincident got su=%b ov=%b want 1 0", start_o, ovr_o);
    end
    tick(); frame = 1; tick();
    checks++;
    if (start_o !== 1'b0 || ovr_o !== 1'b1) begin
      errs++; $display("FAIL overrun got su=%b ov=%b want 0 1", start_o, ovr_o);
    end
    done = 1; tick(); tick(); tick();
    checks++;
    if (ovr_o !== 1'b1) begin errs++; $display("FAIL overrun_sticky got %b want 1", ovr_o); end
    done = 1; tick();
    checks++;
    if (state_o !== 3'd2 || start_o !== 1'b0) begin
      errs++; $display("FAIL stale_done got st=%0d su=%b want 2 0", state_o, start_o);
    end
  endtask

  task automatic test_pause();
    frame = 1; tick(); done = 1; lost = 1; tick();
    checks++;
    if (state_o !== 3'd1) begin errs++; $display("FAIL pause_setup got %0d want 1", state_o); end
    pause = 1; run_frames(SF + 2);
    checks++;
    if (state_o !== 3'd1) begin errs++; $display("FAIL pause_serve got %0d want 1", state_o); end
    pause = 0; run_frames(SF);
    checks++;
    if (state_o !== 3'd2) begin errs++; $display("FAIL unpause_serve got %0d want 2", state_o); end
    pause = 1; frame = 1; tick();
    checks++;
    if (start_o !== 1'b0) begin errs++; $display("FAIL pause_play got su=%b want 0", start_o); end
    pause = 0;
  endtask

  task automatic test_reset_mid();
    frame = 1; tick();
    checks++;
    if (start_o !== 1'b1) begin errs++; $display("FAIL mid_start got %b want 1", start_o); end
    reset = 1; tick(); reset = 0;
    done = 1; lost = 1; blocks = 72'd0; tick(); tick();
    blocks = 72'h1;
    checks++;
    if ({state_o, lives_o, start_o, phys_o, ball_o, ovr_o} !== 10'd0) begin
      errs++; $display("FAIL reset_mid got st=%0d lv=%0d su=%b pr=%b br=%b ov=%b want all 0",
                       state_o, lives_o, start_o, phys_o, ball_o, ovr_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      frame = ($urandom_range(0, 2) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      done  = ($urandom_range(0, 3) == 0);
      lost  = ($urandom_range(0, 4) == 0);
      blocks = ($urandom_range(0, 7) == 0) ? 72'd0 : {8'($urandom), $urandom, $urandom};
      tick();
      checks++;
      if (state_o !== 3'(m_state) || lives_o !== 3'(m_lives) || start_o !== m_start ||
          phys_o !== m_phys || ball_o !== m_ball || ovr_o !== m_ovr) begin
        errs++;
        $display("FAIL random cyc=%0d got st=%0d lv=%0d su=%b pr=%b br=%b ov=%b want %0d %0d %b %b %b %b",
                 c, state_o, lives_o, start_o, phys_o, ball_o, ovr_o,
                 m_state, m_lives, m_start, m_phys, m_ball, m_ovr);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_serve();
    test_lives();
    test_level_clear();
    test_overrun();
    test_pause();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
